elastic_fifo: RTL
=================

// Module: elastic_fifo
// PURPOSE
//  Parametrised synchronous FIFO with valid/ready handshakes on both sides.
//  Runtime almost-full/almost-empty thresholds, an occupancy count output and a resettable
//  high-watermark register. Sits between pipeline stages and memory/IO request queues
//  where backpressure must be handshaked rather than asserted-illegal.
//  Storage is show-ahead: the head entry is always driven on deq_data.
// PARAMETERS
//  WIDTH       64  data bits per entry
//  SIZE        8   entries; power of two, >= 2
//  CNT_W       $clog2(SIZE)+1 (derived localparam)  width of count/threshold/watermark
// PORTS
//  clk             in   1      clock, rising edge
//  reset_n         in   1      asynchronous, active-low reset
//  flush_en        in   1      synchronous flush; discards all entries
//  enq_valid       in   1      producer has data
//  enq_ready       out  1      FIFO can accept (= !full)
//  enq_data        in   WIDTH  data to enqueue
//  deq_valid       out  1      head entry valid (= !empty)
//  deq_ready       in   1      consumer takes head this cycle
//  deq_data        out  WIDTH  head entry (show-ahead)
//  af_thresh       in   CNT_W  almost_full when count >= af_thresh
//  ae_thresh       in   CNT_W  almost_empty when count <= ae_thresh
//  almost_full     out  1      registered-count compare, see above
//  almost_empty    out  1      registered-count compare, see above
//  count           out  CNT_W  current occupancy 0..SIZE
//  high_water      out  CNT_W  max count since reset/flush/wm_clear
//  wm_clear        in   1      synchronous; high_water <= count
// BEHAVIOUR
//  - Reset (reset_n=0, async): head=tail=count=high_water=0, so:
//    - enq_ready=1, deq_valid=0, almost_empty=1 if ae_thresh>=0 (always).
//    - almost_full=(af_thresh==0).
//    - deq_data undefined (storage not reset).
//  - Reset mid-transfer: all pointers clear immediately; in-flight handshakes are lost.
//  - enq fires when enq_valid & enq_ready: data[tail]<=enq_data; tail++ (mod SIZE).
//  - deq fires when deq_valid & deq_ready: head++ (mod SIZE).
//  - count: +1 enq only, -1 deq only, unchanged both/neither.
//  - Full: enq_ready=0; enq_valid ignored even if deq fires same cycle (no full bypass).
//  - Empty: deq_valid=0; deq_ready ignored; no same-cycle pass-through.
//  - Latency: enqueue accepted at edge N -> deq_valid/deq_data visible after edge N (cycle N+1).
//  - Pointers are ADDR-wide and wrap naturally; full/empty from count only.
//  - Flags (almost_full, almost_empty, enq_ready, deq_valid) are combinational from the
//    registered count and threshold inputs; thresholds may change any cycle.
//  - high_water: each edge, if next_count > high_water then high_water <= next_count.
//  - Priority, highest first:
//    1. reset_n
//    2. flush_en: head=tail=count=high_water=0; enq/deq ignored that cycle.
//    3. wm_clear: high_water <= next_count.
//    4. normal update.
//  - No assertion-on-misuse: illegal requests cannot occur by construction.
//    Simulation-only asserts:
//    - count <= SIZE.
//    - enq fired implies !full.
// TESTING
//  1. Reset, SIZE=8: enq 8 words 0x10..0x17 back-to-back with deq_ready=0 -> enq_ready drops
//     after 8th, count=8, high_water=8, deq_data=0x10.
//  2. Full, enq_valid=1 & deq_ready=1 for one cycle -> only deq fires; count=7, 0x10 retired,
//     new enq_data not written.
//  3. Count=3, enq & deq same cycle repeated 20 cycles (wrap twice) -> count stays 3, output
//     order matches input order exactly.
//  4. af_thresh=6, ae_thresh=1; fill 0->7 -> almost_empty at count<=1, almost_full at
//     count>=6; change af_thresh to 2 -> almost_full asserts same cycle.
//  5. Count=5, high_water=8, pulse wm_clear -> high_water=5; then flush_en with enq_valid=1
//     -> count=0, high_water=0, deq_valid=0 next cycle.
//  6. Drop reset_n asynchronously between edges while count=4 -> count=0, enq_ready=1
//     before next edge; random valid/ready soak vs scoreboard shows no loss/duplication.

Source files
------------

// File: rtl/elastic_fifo.sv
// Show-ahead synchronous FIFO with valid/ready on both sides, runtime almost-full/empty
// thresholds, an occupancy count and a clearable high-watermark.
module elastic_fifo #(
    parameter int WIDTH = 64,
    parameter int SIZE  = 8,
    localparam int CNT_W = $clog2(SIZE) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_en,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_data,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_data,
    input  logic [CNT_W-1:0] af_thresh,
    input  logic [CNT_W-1:0] ae_thresh,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] high_water,
    input  logic             wm_clear
);
    localparam int ADDR = $clog2(SIZE);

    logic [WIDTH-1:0] r_mem [SIZE];
    logic [ADDR-1:0]  r_head;
    logic [ADDR-1:0]  r_tail;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_high_water;

    logic             w_full;
    logic             w_empty;
    logic             w_enq_fire;
    logic             w_deq_fire;
    logic [CNT_W-1:0] w_count_next;

    // Full/empty come only from the count, so pointers can wrap freely.
    assign w_full       = (r_count == CNT_W'(SIZE));
    assign w_empty      = (r_count == '0);
    assign enq_ready    = !w_full;
    assign deq_valid    = !w_empty;
    assign w_enq_fire   = enq_valid && enq_ready;
    assign w_deq_fire   = deq_valid && deq_ready;
    assign almost_full  = (r_count >= af_thresh);
    assign almost_empty = (r_count <= ae_thresh);
    assign count        = r_count;
    assign high_water   = r_high_water;
    assign deq_data     = r_mem[r_head];

    always_comb begin
        w_count_next = r_count;
        if (w_enq_fire && !w_deq_fire) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (w_deq_fire && !w_enq_fire) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_high_water <= '0;
        end else if (flush_en) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_high_water <= '0;
        end else begin
            if (w_enq_fire) begin
                r_tail <= r_tail + ADDR'(1);
            end
            if (w_deq_fire) begin
                r_head <= r_head + ADDR'(1);
            end
            r_count <= w_count_next;
            if (wm_clear || (w_count_next > r_high_water)) begin
                r_high_water <= w_count_next;
            end
        end
    end

    // Storage is not reset; contents are only observable once count is non-zero.
    always_ff @(posedge clk) begin
        if (w_enq_fire && !flush_en) begin
            r_mem[r_tail] <= enq_data;
        end
    end

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
        r_count <= CNT_W'(SIZE));
    a_enq_not_full: assert property (@(posedge clk) disable iff (!reset_n)
        w_enq_fire |-> !w_full);
`endif

endmodule
